// File: rtl/id_operand_stage.sv
// id_operand_stage: decode/operand-fetch stage; drives regfile reads, forwards EX/MEM results,
// raises load-use stall requests and registers the decoded bundle into ID/EX.
module id_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              if_valid_i,
    input  logic [31:0]       if_inst_i,
    input  logic [31:0]       if_pc_i,
    output logic              reg1_re_o,
    output logic [ADDR_W-1:0] reg1_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    output logic              reg2_re_o,
    output logic [ADDR_W-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              stallreq_o,
    output logic              ex_valid_o,
    output logic [31:0]       ex_pc_o,
    output logic [5:0]        ex_op_o,
    output logic [DATA_W-1:0] ex_op1_o,
    output logic [DATA_W-1:0] ex_op2_o,
    output logic [DATA_W-1:0] ex_sdata_o,
    output logic [ADDR_W-1:0] ex_waddr_o,
    output logic              ex_wreg_o,
    output logic              ex_illegal_o
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    typedef enum logic [1:0] {SRC_REG, SRC_ZEXT, SRC_SEXT, SRC_LUI} op2_src_t;

    logic [5:0]        w_opcode;
    logic [ADDR_W-1:0] w_rs, w_rt, w_rd;
    logic [15:0]       w_imm;
    logic              w_re1, w_re2, w_wreg, w_illegal;
    logic [ADDR_W-1:0] w_dest;
    logic [5:0]        w_op;
    op2_src_t          w_src2;
    logic [DATA_W-1:0] w_val1, w_val2, w_op2;
    logic              w_haz1, w_haz2;

    logic              r_valid, r_wreg, r_illegal;
    logic [31:0]       r_pc;
    logic [5:0]        r_op;
    logic [DATA_W-1:0] r_op1, r_op2, r_sdata;
    logic [ADDR_W-1:0] r_waddr;

    assign w_opcode = if_inst_i[31:26];
    assign w_rs     = if_inst_i[25:21];
    assign w_rt     = if_inst_i[20:16];
    assign w_rd     = if_inst_i[15:11];
    assign w_imm    = if_inst_i[15:0];

    always_comb begin
        w_re1     = 1'b0;
        w_re2     = 1'b0;
        w_wreg    = 1'b0;
        w_illegal = 1'b0;
        w_dest    = '0;
        w_op      = '0;
        w_src2    = SRC_REG;
        if (if_valid_i) begin
            w_op = w_opcode;
            case (w_opcode)
                OP_SPECIAL: begin
                    // all-zero word is the canonical NOP: no reads, no write
                    w_re1  = |if_inst_i;
                    w_re2  = |if_inst_i;
                    w_wreg = |if_inst_i;
                    w_dest = w_rd;
                    w_op   = if_inst_i[5:0];
                end
                OP_ANDI, OP_ORI, OP_XORI: begin
                    w_re1  = 1'b1;
                    w_wreg = 1'b1;
                    w_dest = w_rt;
                    w_src2 = SRC_ZEXT;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
                    w_re1  = 1'b1;
                    w_wreg = 1'b1;
                    w_dest = w_rt;
                    w_src2 = SRC_SEXT;
                end
                OP_LUI: begin
                    w_wreg = 1'b1;
                    w_dest = w_rt;
                    w_src2 = SRC_LUI;
                end
                OP_SW: begin
                    w_re1  = 1'b1;
                    w_re2  = 1'b1;
                    w_dest = w_rt;
                    w_src2 = SRC_SEXT;
                end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    // EX result takes precedence over MEM: it is the younger write
    function automatic logic [DATA_W-1:0] fwd(input logic re, input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] rf);
        return (!re || a == '0)                ? '0 :
               (ex_we_i && ex_waddr_i == a)    ? ex_wdata_i :
               (mem_we_i && mem_waddr_i == a)  ? mem_wdata_i : rf;
    endfunction

    assign w_val1 = fwd(w_re1, w_rs, reg1_data_i);
    assign w_val2 = fwd(w_re2, w_rt, reg2_data_i);

    assign w_op2 = (w_src2 == SRC_REG)  ? w_val2 :
                   (w_src2 == SRC_ZEXT) ? {{(DATA_W-16){1'b0}}, w_imm} :
                   (w_src2 == SRC_SEXT) ? {{(DATA_W-16){w_imm[15]}}, w_imm} :
                                          {w_imm, {(DATA_W-16){1'b0}}};

    assign w_haz1 = w_re1 && (w_rs != '0) && ex_we_i && ex_is_load_i && (ex_waddr_i == w_rs);
    assign w_haz2 = w_re2 && (w_rt != '0) && ex_we_i && ex_is_load_i && (ex_waddr_i == w_rt);

    assign stallreq_o  = w_haz1 || w_haz2;
    assign reg1_re_o   = w_re1;
    assign reg2_re_o   = w_re2;
    assign reg1_addr_o = w_rs;
    assign reg2_addr_o = w_rt;

    always_ff @(posedge clk) begin
        if (rst || flush_i || (!stall_i && stallreq_o)) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_op      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_sdata   <= '0;
            r_waddr   <= '0;
            r_wreg    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!stall_i) begin
            r_valid   <= if_valid_i;
            r_pc      <= if_pc_i;
            r_op      <= w_op;
            r_op1     <= w_val1;
            r_op2     <= w_op2;
            r_sdata   <= w_val2;
            r_waddr   <= w_dest;
            r_wreg    <= w_wreg;
            r_illegal <= w_illegal;
        end
    end

    assign ex_valid_o   = r_valid;
    assign ex_pc_o      = r_pc;
    assign ex_op_o      = r_op;
    assign ex_op1_o     = r_op1;
    assign ex_op2_o     = r_op2;
    assign ex_sdata_o   = r_sdata;
    assign ex_waddr_o   = r_waddr;
    assign ex_wreg_o    = r_wreg;
    assign ex_illegal_o = r_illegal;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed checks of decode, forwarding, load-use stall and ID/EX control.
module tb_id_operand_stage;
    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, if_valid_i;
    logic [31:0] if_inst_i, if_pc_i;
    logic        reg1_re_o, reg2_re_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_we_i, ex_is_load_i, mem_we_i;
    logic [4:0]  ex_waddr_i, mem_waddr_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        stallreq_o, ex_valid_o, ex_wreg_o, ex_illegal_o;
    logic [31:0] ex_pc_o, ex_op1_o, ex_op2_o, ex_sdata_o;
    logic [5:0]  ex_op_o;
    logic [4:0]  ex_waddr_o;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
        .reg1_re_o(reg1_re_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
        .reg2_re_o(reg2_re_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i), .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i),
        .mem_wdata_i(mem_wdata_i), .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o),
        .ex_pc_o(ex_pc_o), .ex_op_o(ex_op_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
        .ex_sdata_o(ex_sdata_o), .ex_waddr_o(ex_waddr_o), .ex_wreg_o(ex_wreg_o),
        .ex_illegal_o(ex_illegal_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; flush_i = 0; if_valid_i = 1; if_pc_i = 32'h0;
        ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_we_i = 0; mem_waddr_i = 0; mem_wdata_i = 0;
        reg1_data_i = 0; reg2_data_i = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; if_inst_i = 32'h3402_8001; if_pc_i = 32'h44;
        tick(); tick();
        checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_valid_o); end
        checks++; if (ex_wreg_o !== 1'b0 || ex_illegal_o !== 1'b0) begin failures++; $display("FAIL reset_wreg_ill got=%b%b exp=00", ex_wreg_o, ex_illegal_o); end
        checks++; if (ex_pc_o !== 32'h0 || ex_op2_o !== 32'h0) begin failures++; $display("FAIL reset_data got pc=%h op2=%h exp=0", ex_pc_o, ex_op2_o); end
        rst = 0;
    endtask

    task automatic test_imm();
        idle(); if_inst_i = 32'h3402_8001; if_pc_i = 32'h100;   // ORI r2,r0,0x8001
        tick();
        checks++; if (ex_op1_o !== 32'h0 || ex_op2_o !== 32'h0000_8001) begin failures++; $display("FAIL ori_ops got=%h/%h exp=0/00008001", ex_op1_o, ex_op2_o); end
        checks++; if (ex_waddr_o !== 5'd2 || ex_wreg_o !== 1'b1 || ex_valid_o !== 1'b1) begin failures++; $display("FAIL ori_dest got=%0d/%b/%b exp=2/1/1", ex_waddr_o, ex_wreg_o, ex_valid_o); end
        checks++; if (ex_pc_o !== 32'h100 || ex_op_o !== 6'b001101) begin failures++; $display("FAIL ori_pc_op got=%h/%b exp=100/001101", ex_pc_o, ex_op_o); end
        if_inst_i = 32'h2423_FFFF; reg1_data_i = 32'h7;           // ADDIU r3,r1,-1
        #1;
        checks++; if (reg1_re_o !== 1'b1 || reg2_re_o !== 1'b0 || reg1_addr_o !== 5'd1) begin failures++; $display("FAIL addiu_ports got=%b%b a=%0d exp=10 a=1", reg1_re_o, reg2_re_o, reg1_addr_o); end
        tick();
        checks++; if (ex_op1_o !== 32'h7 || ex_op2_o !== 32'hFFFF_FFFF || ex_waddr_o !== 5'd3) begin failures++; $display("FAIL addiu got=%h/%h/%0d exp=7/ffffffff/3", ex_op1_o, ex_op2_o, ex_waddr_o); end
        if_inst_i = 32'h3C04_1234;                                // LUI r4,0x1234
        #1;
        checks++; if (reg1_re_o !== 1'b0 || reg2_re_o !== 1'b0) begin failures++; $display("FAIL lui_re got=%b%b exp=00", reg1_re_o, reg2_re_o); end
        tick();
        checks++; if (ex_op1_o !== 32'h0 || ex_op2_o !== 32'h1234_0000 || ex_waddr_o !== 5'd4) begin failures++; $display("FAIL lui got=%h/%h/%0d exp=0/12340000/4", ex_op1_o, ex_op2_o, ex_waddr_o); end
    endtask

    task automatic test_forward();
        idle(); if_inst_i = {6'b0, 5'd1, 5'd1, 5'd5, 5'd0, 6'h21};  // ADDU r5,r1,r1
        ex_we_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'hA;
        mem_we_i = 1; mem_waddr_i = 1; mem_wdata_i = 32'hB;
        reg1_data_i = 32'hC; reg2_data_i = 32'hC;
        #1;
        checks++; if (stallreq_o !== 1'b0 || reg1_re_o !== 1'b1 || reg2_re_o !== 1'b1) begin failures++; $display("FAIL addu_comb got st=%b re=%b%b exp=0 11", stallreq_o, reg1_re_o, reg2_re_o); end
        tick();
        checks++; if (ex_op1_o !== 32'hA || ex_op2_o !== 32'hA || ex_sdata_o !== 32'hA) begin failures++; $display("FAIL fwd_ex got=%h/%h/%h exp=a", ex_op1_o, ex_op2_o, ex_sdata_o); end
        checks++; if (ex_op_o !== 6'h21 || ex_waddr_o !== 5'd5 || ex_wreg_o !== 1'b1) begin failures++; $display("FAIL addu_dec got=%h/%0d/%b exp=21/5/1", ex_op_o, ex_waddr_o, ex_wreg_o); end
        ex_we_i = 0;
        tick();
        checks++; if (ex_op1_o !== 32'hB || ex_op2_o !== 32'hB) begin failures++; $display("FAIL fwd_mem got=%h/%h exp=b", ex_op1_o, ex_op2_o); end
        mem_we_i = 0;
        tick();
        checks++; if (ex_op1_o !== 32'hC || ex_op2_o !== 32'hC) begin failures++; $display("FAIL fwd_rf got=%h/%h exp=c", ex_op1_o, ex_op2_o); end
        if_inst_i = {6'b0, 5'd0, 5'd0, 5'd5, 5'd0, 6'h21};         // ADDU r5,r0,r0 with load to r0
        ex_we_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'h99; ex_is_load_i = 1;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL load_r0_stall got=%b exp=0", stallreq_o); end
        tick();
        checks++; if (ex_op1_o !== 32'h0 || ex_op2_o !== 32'h0 || ex_valid_o !== 1'b1) begin failures++; $display("FAIL r0_zero got=%h/%h v=%b exp=0/0 v=1", ex_op1_o, ex_op2_o, ex_valid_o); end
    endtask

    task automatic test_load_use();
        idle(); if_inst_i = {6'b101011, 5'd1, 5'd6, 16'h0004}; if_pc_i = 32'h200;  // SW r6,4(r1)
        reg1_data_i = 32'h10; reg2_data_i = 32'h99;
        ex_we_i = 1; ex_waddr_i = 6; ex_wdata_i = 32'hDEAD; ex_is_load_i = 1;
        #1;
        checks++; if (stallreq_o !== 1'b1) begin failures++; $display("FAIL lu_stallreq got=%b exp=1", stallreq_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b0 || ex_sdata_o !== 32'h0 || ex_op1_o !== 32'h0) begin failures++; $display("FAIL lu_bubble got v=%b sd=%h op1=%h exp=0", ex_valid_o, ex_sdata_o, ex_op1_o); end
        ex_we_i = 0; ex_is_load_i = 0; mem_we_i = 1; mem_waddr_i = 6; mem_wdata_i = 32'h55;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", stallreq_o); end
        tick();
        checks++; if (ex_sdata_o !== 32'h55 || ex_op1_o !== 32'h10 || ex_op2_o !== 32'h4) begin failures++; $display("FAIL sw_data got=%h/%h/%h exp=55/10/4", ex_sdata_o, ex_op1_o, ex_op2_o); end
        checks++; if (ex_valid_o !== 1'b1 || ex_wreg_o !== 1'b0 || ex_op_o !== 6'b101011) begin failures++; $display("FAIL sw_ctrl got=%b/%b/%b exp=1/0/101011", ex_valid_o, ex_wreg_o, ex_op_o); end
        if_valid_i = 0; ex_we_i = 1; ex_is_load_i = 1; mem_we_i = 0;
        #1;
        checks++; if (stallreq_o !== 1'b0 || reg1_re_o !== 1'b0) begin failures++; $display("FAIL invalid_nop got st=%b re=%b exp=0", stallreq_o, reg1_re_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0) begin failures++; $display("FAIL invalid_slot got=%b%b exp=00", ex_valid_o, ex_wreg_o); end
    endtask

    task automatic test_stall_flush();
        idle(); if_inst_i = 32'h3407_00FF; if_pc_i = 32'h300;     // ORI r7,r0,0xFF
        tick();
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            if_inst_i = 32'h3C08_0000 + i; if_pc_i = 32'h304 + 4 * i;
            tick();
            checks++; if (ex_op2_o !== 32'hFF || ex_waddr_o !== 5'd7 || ex_pc_o !== 32'h300 || ex_valid_o !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got=%h/%0d/%h/%b exp=ff/7/300/1", i, ex_op2_o, ex_waddr_o, ex_pc_o, ex_valid_o); end
        end
        flush_i = 1;
        tick();
        checks++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0 || ex_op2_o !== 32'h0) begin failures++; $display("FAIL flush_wins got=%b/%b/%h exp=0/0/0", ex_valid_o, ex_wreg_o, ex_op2_o); end
        flush_i = 0; stall_i = 0;
        tick();
        stall_i = 1; ex_we_i = 1; ex_waddr_i = 2; ex_is_load_i = 1;
        if_inst_i = {6'b0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h21};
        rst = 1;
        tick();
        checks++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b%b exp=00", ex_valid_o, ex_wreg_o); end
        rst = 0; stall_i = 0; ex_we_i = 0; ex_is_load_i = 0;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL rst_stallreq got=%b exp=0", stallreq_o); end
    endtask

    task automatic test_illegal_nop();
        idle(); if_inst_i = {6'b111111, 5'd1, 5'd2, 16'h0};
        #1;
        checks++; if (reg1_re_o !== 1'b0 || reg2_re_o !== 1'b0) begin failures++; $display("FAIL illegal_re got=%b%b exp=00", reg1_re_o, reg2_re_o); end
        tick();
        checks++; if (ex_illegal_o !== 1'b1 || ex_wreg_o !== 1'b0 || ex_valid_o !== 1'b1) begin failures++; $display("FAIL illegal got=%b/%b/%b exp=1/0/1", ex_illegal_o, ex_wreg_o, ex_valid_o); end
        if_inst_i = 32'h0; ex_we_i = 1; ex_waddr_i = 0; ex_is_load_i = 1;
        #1;
        checks++; if (stallreq_o !== 1'b0 || reg1_re_o !== 1'b0) begin failures++; $display("FAIL nop_comb got st=%b re=%b exp=0", stallreq_o, reg1_re_o); end
        tick();
        checks++; if (ex_wreg_o !== 1'b0 || ex_illegal_o !== 1'b0 || ex_valid_o !== 1'b1) begin failures++; $display("FAIL nop got=%b/%b/%b exp=0/0/1", ex_wreg_o, ex_illegal_o, ex_valid_o); end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_illegal_nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
Decode/operand-fetch stage of the 5-stage pipeline, acting as the read-side initiator of the register file.
- Decodes the instruction from IF/ID and drives both register-file read ports.
- Selects operands with priority: EX-stage forward, then MEM-stage forward, then register-file data.
- Detects load-use hazards and raises a stall request.
- Registers the decoded bundle into the ID/EX pipeline register.

Parameters:
DATA_W, 32, data/operand width
ADDR_W, 5, register address width (32 registers, r0 hard-wired zero)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stall_i  in  1  EX stage stalled; hold ID/EX contents
flush_i  in  1  squash; load bubble into ID/EX
if_valid_i  in  1  IF/ID holds a valid instruction
if_inst_i  in  32  instruction word
if_pc_i  in  32  instruction PC
reg1_re_o  out  1  read enable, port 1 (rs)
reg1_addr_o  out  ADDR_W  read address, port 1
reg1_data_i  in  DATA_W  read data, port 1 (WB bypass handled in register file)
reg2_re_o  out  1  read enable, port 2 (rt)
reg2_addr_o  out  ADDR_W  read address, port 2
reg2_data_i  in  DATA_W  read data, port 2
ex_we_i / ex_waddr_i / ex_wdata_i  in  1/ADDR_W/DATA_W  EX-stage result being produced
ex_is_load_i  in  1  EX-stage instruction is a load (data not yet available)
mem_we_i / mem_waddr_i / mem_wdata_i  in  1/ADDR_W/DATA_W  MEM-stage result
stallreq_o  out  1  load-use stall request to pipeline control
ex_valid_o  out  1  ID/EX slot valid
ex_pc_o  out  32  PC
ex_op_o  out  6  opcode, or funct for SPECIAL (ALU selector)
ex_op1_o / ex_op2_o  out  DATA_W  ALU operands
ex_sdata_o  out  DATA_W  store data (rt value)
ex_waddr_o  out  ADDR_W  destination register
ex_wreg_o  out  1  destination write enable
ex_illegal_o  out  1  unknown opcode flag

Behaviour:
Decode (combinational). Fields: opcode = inst[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
- SPECIAL (000000): re1 = re2 = 1; op1 = rs, op2 = rt; dest = rd; wreg = 1. Exception: an all-zero word (NOP) forces wreg = 0, re1 = re2 = 0.
- ANDI/ORI/XORI (001100/001101/001110): re1 = 1, re2 = 0; op2 = zero-extended imm; dest = rt; wreg = 1.
- ADDI/ADDIU/SLTI (001000/001001/001010): same as above but op2 = sign-extended imm.
- LUI (001111): re1 = re2 = 0; op1 = 0; op2 = {imm, 16'h0}; dest = rt; wreg = 1.
- LW (100011): re1 = 1; op2 = sign-extended imm; dest = rt; wreg = 1.
- SW (101011): re1 = re2 = 1; op2 = sign-extended imm; sdata = rt value; wreg = 0.
- Any other opcode: re1 = re2 = 0, wreg = 0, illegal = 1.
- if_valid_i = 0: treat as NOP; no reads, no stall request.
- reg*_addr_o always equals rs/rt. reg*_re_o follows the decode.

Operand value per port, in priority order:
1. re = 0 -> value 0.
2. addr = 0 -> value 0.
3. ex_we_i && ex_waddr_i == addr -> ex_wdata_i.
4. mem_we_i && mem_waddr_i == addr -> mem_wdata_i.
5. Otherwise -> reg*_data_i.

Load-use stall:
- stallreq_o = 1 when, for either port, re && addr != 0 && ex_we_i && ex_is_load_i && ex_waddr_i == addr.
- Combinational; same cycle.
- Pipeline control holds PC and IF/ID while stallreq_o is high. This block does not hold them itself.

ID/EX register update (posedge clk), priority order:
1. rst: all ex_* outputs = 0 (valid 0, wreg 0, illegal 0).
2. flush_i: bubble, i.e. all ex_* = 0. Overrides stall_i and stallreq_o.
3. stall_i: hold every ex_* output unchanged.
4. stallreq_o: bubble into EX.
5. Otherwise: capture the decoded bundle with ex_valid_o = if_valid_i.

Timing and reset:
- Latency: one cycle from IF/ID contents to ex_* outputs.
- Reset asserted mid-stall clears the slot; stallreq_o returns to 0 once EX inputs deassert.
- stallreq_o and read-port outputs are combinational and have no reset value of their own.

Boundary cases:
- Both ports reading the same register: both forward identically.
- EX and MEM both target the same address: EX wins.
- Load targeting r0: no stall.
- ADDR_W and DATA_W are fixed at 5/32 for this ISA; other values are not supported.

Test Plan:
- Reset then ORI r2, r0, 0x8001 with regfile data 0 -> next cycle: ex_op1 = 0, ex_op2 = 0x00008001, ex_waddr = 2, ex_wreg = 1, ex_valid = 1.
- ADDIU r3, r1, 0xFFFF -> ex_op2 = 0xFFFFFFFF. LUI r4, 0x1234 -> ex_op2 = 0x12340000, reg1_re_o = 0.
- ADDU r5, r1, r1 with EX writing r1 = 0xA, MEM writing r1 = 0xB, regfile 0xC -> both operands 0xA. Drop EX -> both 0xB. Drop MEM -> both 0xC.
- SW with EX load to rt (ex_is_load_i = 1) -> stallreq_o = 1 and ID/EX loads a bubble. Next cycle with load in MEM -> stallreq_o = 0, ex_sdata = mem_wdata_i.
- stall_i high for 3 cycles while the instruction changes -> ex_* outputs frozen. flush_i together with stall_i -> bubble wins.
- Opcode 111111 -> ex_illegal = 1, ex_wreg = 0, no reads. Instruction word 0 -> ex_wreg = 0, stallreq_o = 0 even when the EX load targets r0.
